sgd_gradient_scheduler: RTL

- Sequences the per-sample gradient pass of the SGD engine.
- Latches run configuration on `started`.
- On each dot-product-valid event, issues exactly chunks×bits feature-FIFO reads in bit-inner / chunk-outer order, queueing at most one early sample.
- Counts samples and epochs, reporting sample, epoch and run completion.
- Sits between the dot-product stage and the gradient adder trees; drives their FIFO read enable.

---
 rtl/sgd_sched_pkg.sv | 28 ++
 rtl/sgd_nested_loop_counter.sv | 44 ++++
 rtl/sgd_gradient_scheduler.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sgd_sched_pkg.sv
// Shared types and defaults for the SGD gradient scheduler.
package sgd_sched_pkg;

  localparam int CHUNK_LOG2_DEFAULT = 9;
  localparam int MAX_BITS_DEFAULT   = 16;
  localparam int BIT_IDX_W          = 5;
  localparam int BIT_LIM_W          = BIT_IDX_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DOT,
    STREAM,
    SAMPLE_END,
    DONE
  } sched_state_t;

  // Precision 0 is treated as 1 bit; anything above the supported maximum is capped.
  function automatic logic [BIT_LIM_W-1:0] clamp_bits(input logic [5:0] raw, input int max_bits);
    if (raw == 6'd0) begin
      return BIT_LIM_W'(1);
    end else if (int'(raw) > max_bits) begin
      return BIT_LIM_W'(max_bits);
    end else begin
      return raw;
    end
  endfunction

endpackage

// File: rtl/sgd_nested_loop_counter.sv
// Two-level bit/chunk counter: bit index is the inner loop, chunk index the outer.
// Advances only when 'advance' is high and wraps both levels after the last position.
module sgd_nested_loop_counter
  import sgd_sched_pkg::*;
#(
  parameter int CNT_W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 advance,
  input  logic [BIT_LIM_W-1:0] bit_limit,
  input  logic [CNT_W-1:0]     chunk_limit,
  output logic [BIT_IDX_W-1:0] bit_idx,
  output logic [CNT_W-1:0]     chunk_idx,
  output logic                 last
);

  logic bit_wrap;
  logic chunk_wrap;

  // Detect the final position of each loop level.
  always_comb begin
    bit_wrap   = ({1'b0, bit_idx} == (bit_limit - BIT_LIM_W'(1)));
    chunk_wrap = (chunk_idx == (chunk_limit - CNT_W'(1)));
    last       = bit_wrap && chunk_wrap;
  end

  // Step bit-inner, chunk-outer on each issued read.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      bit_idx   <= '0;
      chunk_idx <= '0;
    end else if (advance) begin
      if (bit_wrap) begin
        bit_idx   <= '0;
        chunk_idx <= chunk_wrap ? '0 : chunk_idx + CNT_W'(1);
      end else begin
        bit_idx <= bit_idx + BIT_IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/sgd_gradient_scheduler.sv
// Sequences the per-sample gradient pass: for every dot-product-valid event it issues
// chunks x bits feature-FIFO reads, tracks samples/epochs and flags lost events.
// Optional performance counters are built when SGD_GRAD_SCHED_PERF_EN is defined.
module sgd_gradient_scheduler
  import sgd_sched_pkg::*;
#(
  parameter int CHUNK_LOG2 = CHUNK_LOG2_DEFAULT,
  parameter int MAX_BITS   = MAX_BITS_DEFAULT,
  parameter int CNT_W      = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 started,
  input  logic [31:0]          number_of_epochs,
  input  logic [31:0]          number_of_samples,
  input  logic [31:0]          dimension,
  input  logic [31:0]          number_of_bits,
  input  logic                 dot_valid,
  input  logic                 fifo_a_empty,
  output logic                 fifo_a_rd_en,
  output logic [BIT_IDX_W-1:0] rd_bit_idx,
  output logic [CNT_W-1:0]     rd_chunk_idx,
  output logic                 sample_done,
  output logic                 epoch_done,
  output logic                 all_done,
  output logic                 busy,
  output logic                 overrun_err,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_busy_cnt
);

  sched_state_t         state;
  sched_state_t         state_nxt;
  logic [31:0]          epochs_cfg;
  logic [31:0]          samples_cfg;
  logic [CNT_W-1:0]     chunks_cfg;
  logic [BIT_LIM_W-1:0] bits_cfg;
  logic [31:0]          sample_cnt;
  logic [31:0]          epoch_cnt;
  logic                 pending;
  logic                 last_read;
  logic                 sample_last;
  logic                 epoch_last;
  logic [31:0]          chunks_calc;
  logic                 unused_inputs;

  // A partial trailing chunk still costs a full chunk of reads.
  assign chunks_calc   = (dimension >> CHUNK_LOG2) + {31'b0, |dimension[CHUNK_LOG2-1:0]};
  assign sample_last   = (sample_cnt == (samples_cfg - 32'd1));
  assign epoch_last    = (epoch_cnt == (epochs_cfg - 32'd1));
  assign unused_inputs = ^{number_of_bits[31:6], chunks_calc[31:CNT_W]};

  // Next-state and strobe decode.
  always_comb begin
    state_nxt    = state;
    fifo_a_rd_en = 1'b0;
    sample_done  = 1'b0;
    epoch_done   = 1'b0;
    all_done     = 1'b0;
    busy         = 1'b0;
    case (state)
      IDLE: begin
        if (started) begin
          state_nxt = ((number_of_epochs == 32'd0) || (number_of_samples == 32'd0)) ? DONE : WAIT_DOT;
        end
      end
      WAIT_DOT: begin
        busy = 1'b1;
        if (dot_valid) begin
          state_nxt = (chunks_cfg == '0) ? SAMPLE_END : STREAM;
        end
      end
      STREAM: begin
        busy         = 1'b1;
        fifo_a_rd_en = !fifo_a_empty;
        if (fifo_a_rd_en && last_read) begin
          state_nxt = SAMPLE_END;
        end
      end
      SAMPLE_END: begin
        busy        = 1'b1;
        sample_done = 1'b1;
        epoch_done  = sample_last;
        if (sample_last && epoch_last) begin
          state_nxt = DONE;
        end else if (pending || dot_valid) begin
          state_nxt = (chunks_cfg == '0) ? SAMPLE_END : STREAM;
        end else begin
          state_nxt = WAIT_DOT;
        end
      end
      DONE: begin
        all_done = 1'b1;
        if (!started) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture run configuration when a run is requested from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      epochs_cfg  <= '0;
      samples_cfg <= '0;
      chunks_cfg  <= '0;
      bits_cfg    <= '0;
    end else if ((state == IDLE) && started) begin
      epochs_cfg  <= number_of_epochs;
      samples_cfg <= number_of_samples;
      chunks_cfg  <= chunks_calc[CNT_W-1:0];
      bits_cfg    <= clamp_bits(number_of_bits[5:0], MAX_BITS);
    end
  end

  // Sample and epoch progress, updated once per completed sample.
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE)) begin
      sample_cnt <= '0;
      epoch_cnt  <= '0;
    end else if (state == SAMPLE_END) begin
      if (sample_last) begin
        sample_cnt <= '0;
        if (!epoch_last) begin
          epoch_cnt <= epoch_cnt + 32'd1;
        end
      end else begin
        sample_cnt <= sample_cnt + 32'd1;
      end
    end
  end

  // One-deep queue for an early dot_valid; a second early event is lost and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      case (state)
        IDLE: pending <= 1'b0;
        STREAM: begin
          if (dot_valid) begin
            if (pending) begin
              overrun_err <= 1'b1;
            end else begin
              pending <= 1'b1;
            end
          end
        end
        SAMPLE_END: begin
          if (dot_valid && pending) begin
            overrun_err <= 1'b1;
          end
          pending <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  sgd_nested_loop_counter #(
    .CNT_W(CNT_W)
  ) u_loop_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == IDLE),
    .advance    (fifo_a_rd_en),
    .bit_limit  (bits_cfg),
    .chunk_limit(chunks_cfg),
    .bit_idx    (rd_bit_idx),
    .chunk_idx  (rd_chunk_idx),
    .last       (last_read)
  );

`ifdef SGD_GRAD_SCHED_PERF_EN
  logic run_start;
  assign run_start = (state == IDLE) && (state_nxt == WAIT_DOT);

  // Saturating stall and busy cycle counters, restarted at each run.
  always_ff @(posedge clk) begin
    if (rst || run_start) begin
      perf_stall_cnt <= '0;
      perf_busy_cnt  <= '0;
    end else begin
      if ((state == STREAM) && fifo_a_empty && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (busy && (perf_busy_cnt != '1)) begin
        perf_busy_cnt <= perf_busy_cnt + 32'd1;
      end
    end
  end
`else
  assign perf_stall_cnt = '0;
  assign perf_busy_cnt  = '0;
`endif

endmodule
